uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Buffers bytes written by the CPU to the UART data address (0x00004000) in a small FIFO.
- Sequences the uart_tx transmitter: one byte at a time, issuing a single-cycle write strobe only when the transmitter is free.
- Sits between the MMU and uart_tx, so a CPU store to UART no longer waits for uart_busy.
- Supplies status bits that the MMU returns on UART_STATUS (0x00004004) reads.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, at least 2.
- DATA_W, 8: byte width handed to uart_tx.
- BUSY_TIMEOUT, 15: cycles to wait for uart_busy to rise after a strobe before abandoning the wait.

Ports:
- clk  in  1  system clock (clk_from_FPGA domain).
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request from MMU (UART data address store).
- wr_data  in  DATA_W  byte to push.
- clr_overflow  in  1  clears the sticky overflow flag.
- uart_busy  in  1  busy from uart_tx.
- uart_write_en  out  1  one-cycle start strobe to uart_tx.
- uart_data  out  DATA_W  byte presented to uart_tx; stable while uart_write_en is high.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a push was dropped.
- tx_idle  out  1  fifo_empty and state is IDLE and uart_busy is low.

Behaviour:
- Reset: asynchronous, active-high; applies immediately, including mid-transmit.
  - State goes to IDLE; pointers and count go to 0.
  - uart_write_en=0, uart_data=0, overflow=0, fifo_empty=1, fifo_full=0, tx_idle=1.
  - uart_tx shares rst, so any in-flight frame is aborted with it.
- FIFO: synchronous, registered pointers with wrap-around modulo DEPTH.
  - Push is accepted when wr_en=1 and (not full, or a pop occurs in the same cycle).
  - Push when full with no pop: byte dropped, overflow set next cycle.
  - Push and pop in the same cycle: count unchanged; both succeed at any occupancy except empty.
  - When empty, a push and a would-be pop in the same cycle resolve as push only; no bypass.
- FSM states:
  - IDLE: if not fifo_empty and uart_busy=0, go to ISSUE.
  - ISSUE:
    - Drive uart_write_en=1 for exactly one cycle with uart_data = FIFO head.
    - Pop the head in the same cycle.
    - Go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY:
    - If uart_busy=1, go to WAIT_DONE.
    - Otherwise, once the counter reaches BUSY_TIMEOUT, go to IDLE. The byte counts as sent and is not retried.
  - WAIT_DONE: when uart_busy=0, go to IDLE.
- Throughput and latency:
  - The earliest next ISSUE is 2 cycles after busy falls (WAIT_DONE to IDLE, then IDLE to ISSUE). This guarantees at least one idle cycle between frames.
  - Push to strobe latency is 2 cycles when the FIFO was empty and the UART is idle:
    - push at cycle N;
    - fifo_empty=0 at N+1, so IDLE goes to ISSUE;
    - strobe at N+2.
- uart_data is registered from the FIFO head on entry to ISSUE and holds its value after the strobe.
- overflow:
  - Set by a dropped push.
  - Cleared by clr_overflow.
  - If both occur in the same cycle, set wins.
- Status outputs are combinational from registered state; none depend combinationally on wr_en.

Optional Feature:
- Macro: UART_TX_SCHED_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 empties the FIFO synchronously (pointers and count to 0) and discards any same-cycle push.
  - The FSM is not disturbed: a byte already issued completes normally.
  - overflow is unaffected.
- When undefined: the port is absent and there is no flush logic.

Decomposition:
- Package uart_sched_pkg holds:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3;
  - UART_DATA_ADDR=32'h00004000 and UART_STATUS_ADDR=32'h00004004;
  - status bit positions for the MMU: bit0 tx_idle, bit1 fifo_full, bit2 fifo_empty, bit3 overflow.
- Sub-module sync_fifo (DEPTH, DATA_W): pointers, count, full and empty. The FSM, timeout counter and overflow flag stay in uart_tx_scheduler.

Test Plan:
- Reset then push 0x41 with uart_busy low → uart_write_en high for exactly one cycle 2 cycles later with uart_data=0x41; fifo_empty returns to 1.
- Push 0x48,0x49,0x21 back-to-back, with the busy model high for 100 cycles after each strobe → 3 strobes in order, each at least 2 cycles after busy falls; fifo_count peaks at 2 (the first byte pops on issue).
- Push 17 bytes with uart_busy held high → fifo_full=1 at count 16, the 17th byte dropped, overflow=1; clr_overflow → overflow=0; on release, the 16 bytes drain in order.
- At full, push while an ISSUE pop occurs → push accepted, count stays 16, overflow stays 0.
- Strobe with uart_busy never rising → return to IDLE after 15 WAIT_BUSY cycles; the next byte issues.
- Assert rst asynchronously during WAIT_DONE with 5 bytes queued → all outputs at reset values immediately (no clock edge needed), fifo_count=0; no strobe after release.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// ============================================================================
// Module   : uart_sched_pkg
// Brief    : Shared encodings for the UART transmit scheduler and the MMU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_sched_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = IDLE,
    S_ISSUE     = ISSUE,
    S_WAIT_BUSY = WAIT_BUSY,
    S_WAIT_DONE = WAIT_DONE
  } sched_state_t;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h0000_4000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_4004;

  // Bit positions of the UART_STATUS word returned by the MMU
  localparam int STATUS_TX_IDLE_BIT    = 0;
  localparam int STATUS_FIFO_FULL_BIT  = 1;
  localparam int STATUS_FIFO_EMPTY_BIT = 2;
  localparam int STATUS_OVERFLOW_BIT   = 3;

  function automatic logic [3:0] pack_status(input logic tx_idle,
                                             input logic fifo_full,
                                             input logic fifo_empty,
                                             input logic overflow);
    logic [3:0] v;
    v = '0;
    v[STATUS_TX_IDLE_BIT]    = tx_idle;
    v[STATUS_FIFO_FULL_BIT]  = fifo_full;
    v[STATUS_FIFO_EMPTY_BIT] = fifo_empty;
    v[STATUS_OVERFLOW_BIT]   = overflow;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered pointers, occupancy and clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Queues CPU bytes and paces single-cycle start strobes to uart_tx.
//            Optional flush port enabled by UART_TX_SCHED_FLUSH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_overflow,
  input  logic                   uart_busy,
  output logic                   uart_write_en,
  output logic [DATA_W-1:0]      uart_data,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   tx_idle
`ifdef UART_TX_SCHED_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [TW-1:0]     r_tmo;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_drop;
  logic              w_flush;

`ifdef UART_TX_SCHED_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_flush),
    .push    (wr_en),
    .pop     (w_pop),
    .wr_data (wr_data),
    .rd_data (w_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!fifo_empty && !uart_busy) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
      // A transmitter that never acknowledges must not stall the queue
      S_WAIT_BUSY: begin
        if (uart_busy)                 w_state_nxt = S_WAIT_DONE;
        else if (r_tmo == C_TMO_LAST)  w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!uart_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop  = (r_state == S_ISSUE);
  assign w_drop = wr_en && fifo_full && !w_pop && !w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ISSUE)          r_tmo <= '0;
      else if (r_state == S_WAIT_BUSY) r_tmo <= r_tmo + 1'b1;
      if (r_state == S_IDLE && w_state_nxt == S_ISSUE) r_data <= w_head;
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign uart_write_en = (r_state == S_ISSUE);
  assign uart_data     = r_data;
  assign overflow      = r_overflow;
  assign tx_idle       = fifo_empty && (r_state == S_IDLE) && !uart_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Directed self-checking bench for uart_tx_scheduler with busy model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       uart_busy;
  logic       uart_write_en;
  logic [7:0] uart_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       tx_idle;
`ifdef UART_TX_SCHED_FLUSH_EN
  logic       flush = 1'b0;
`endif

  logic       busy_force = 1'b0;
  logic       model_en = 1'b0;
  int         model_cnt;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] sd[$];
  int         sc[$];
  int         gaps[$];

  uart_tx_scheduler #(
    .DEPTH        (16),
    .DATA_W       (8),
    .BUSY_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .clr_overflow  (clr_overflow),
    .uart_busy     (uart_busy),
    .uart_write_en (uart_write_en),
    .uart_data     (uart_data),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .tx_idle       (tx_idle)
`ifdef UART_TX_SCHED_FLUSH_EN
    ,
    .flush         (flush)
`endif
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy for 100 cycles after each strobe, shares rst
  always @(posedge clk or posedge rst) begin
    if (rst)                            model_cnt <= 0;
    else if (model_en && uart_write_en) model_cnt <= 100;
    else if (model_cnt > 0)             model_cnt <= model_cnt - 1;
  end
  assign uart_busy = busy_force | (model_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_write_en) begin
      sd.push_back(uart_data);
      sc.push_back(cyc);
      gaps.push_back(cyc - fall_cyc);
    end
    if (busy_prev && !uart_busy) fall_cyc = cyc;
    busy_prev = uart_busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (!tx_idle && n < maxc) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, tx_idle}, 32'd1);
  endtask

  task automatic clear_log();
    sd.delete();
    sc.delete();
    gaps.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    int n0;

    // Reset values
    tick(3);
    check("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_idle", {31'd0, tx_idle}, 32'd1);
    check("rst_we", {31'd0, uart_write_en}, 32'd0);
    check("rst_data", {24'd0, uart_data}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single byte: strobe two cycles after the push
    clear_log();
    push(8'h41);
    check("t1_we_n1", {31'd0, uart_write_en}, 32'd0);
    check("t1_empty_n1", {31'd0, fifo_empty}, 32'd0);
    tick(1);
    check("t1_we_n2", {31'd0, uart_write_en}, 32'd1);
    check("t1_data_n2", {24'd0, uart_data}, 32'h41);
    tick(1);
    check("t1_we_n3", {31'd0, uart_write_en}, 32'd0);
    check("t1_empty_n3", {31'd0, fifo_empty}, 32'd1);
    check("t1_data_hold", {24'd0, uart_data}, 32'h41);
    wait_idle("t1_idle", 40);
    check("t1_nstrobe", sd.size(), 32'd1);

    // Three bytes paced by a 100-cycle busy
    model_en = 1'b1;
    clear_log();
    peak = 0;
    push(8'h48); if (fifo_count > peak) peak = fifo_count;
    push(8'h49); if (fifo_count > peak) peak = fifo_count;
    push(8'h21); if (fifo_count > peak) peak = fifo_count;
    for (int i = 0; i < 600 && !(sd.size() == 3 && tx_idle); i++) begin
      tick(1);
      if (fifo_count > peak) peak = fifo_count;
    end
    check("t2_peak", peak, 32'd2);
    check("t2_nstrobe", sd.size(), 32'd3);
    if (sd.size() == 3) begin
      check("t2_d0", {24'd0, sd[0]}, 32'h48);
      check("t2_d1", {24'd0, sd[1]}, 32'h49);
      check("t2_d2", {24'd0, sd[2]}, 32'h21);
      check("t2_gap1", {31'd0, gaps[1] >= 2}, 32'd1);
      check("t2_gap2", {31'd0, gaps[2] >= 2}, 32'd1);
    end

    // Fill to full with busy held, overflow on the 17th
    busy_force = 1'b1;
    tick(2);
    clear_log();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check("t3_count16", {27'd0, fifo_count}, 32'd16);
    check("t3_full", {31'd0, fifo_full}, 32'd1);
    check("t3_ovf0", {31'd0, overflow}, 32'd0);
    push(8'h20);
    check("t3_ovf1", {31'd0, overflow}, 32'd1);
    check("t3_count_drop", {27'd0, fifo_count}, 32'd16);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t3_ovf_clr", {31'd0, overflow}, 32'd0);

    // Push during the issue pop at full
    busy_force = 1'b0;
    tick(1);
    check("t4_we", {31'd0, uart_write_en}, 32'd1);
    check("t4_data", {24'd0, uart_data}, 32'h10);
    push(8'h99);
    check("t4_count", {27'd0, fifo_count}, 32'd16);
    check("t4_full", {31'd0, fifo_full}, 32'd1);
    check("t4_ovf", {31'd0, overflow}, 32'd0);
    wait_idle("t4_idle", 3000);
    check("t4_nstrobe", sd.size(), 32'd17);
    if (sd.size() == 17) begin
      for (int i = 0; i < 16; i++) check("t4_order", {24'd0, sd[i]}, 32'h10 + i);
      check("t4_last", {24'd0, sd[16]}, 32'h99);
    end

    // Busy never rises: 15 WAIT_BUSY cycles then next byte
    model_en = 1'b0;
    clear_log();
    push(8'hA5);
    push(8'h5A);
    wait_idle("t5_idle", 100);
    check("t5_nstrobe", sd.size(), 32'd2);
    if (sd.size() == 2) begin
      check("t5_d0", {24'd0, sd[0]}, 32'hA5);
      check("t5_d1", {24'd0, sd[1]}, 32'h5A);
      check("t5_spacing", sc[1] - sc[0], 32'd17);
    end

    // Asynchronous reset in WAIT_DONE with 5 queued
    model_en = 1'b1;
    clear_log();
    for (int i = 1; i <= 6; i++) push(8'(i));
    tick(5);
    check("t6_count5", {27'd0, fifo_count}, 32'd5);
    check("t6_busy", {31'd0, uart_busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_count", {27'd0, fifo_count}, 32'd0);
    check("t6_empty", {31'd0, fifo_empty}, 32'd1);
    check("t6_full", {31'd0, fifo_full}, 32'd0);
    check("t6_we", {31'd0, uart_write_en}, 32'd0);
    check("t6_data", {24'd0, uart_data}, 32'd0);
    check("t6_ovf", {31'd0, overflow}, 32'd0);
    check("t6_idle", {31'd0, tx_idle}, 32'd1);
    n0 = sd.size();
    tick(2);
    rst = 1'b0;
    tick(30);
    check("t6_no_strobe", sd.size(), n0);
    check("t6_empty_after", {31'd0, fifo_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
